// File: rtl/arcade_inputs_pkg.sv
// Shared constants for the arcade control-input front end:
// scan codes, joystick bit positions and the coin counter width.
package arcade_inputs_pkg;

  localparam logic [8:0] SC_START1   = 9'h016;
  localparam logic [8:0] SC_START2   = 9'h01E;
  localparam logic [8:0] SC_COIN1    = 9'h02E;
  localparam logic [8:0] SC_COIN2    = 9'h036;
  localparam logic [8:0] SC_F3       = 9'h004;
  localparam logic [8:0] SC_SERVICE  = 9'h046;
  localparam logic [8:0] SC_P1_FIRE  = 9'h014;
  localparam logic [8:0] SC_P1_BOMB  = 9'h011;
  localparam logic [8:0] SC_P2_UP    = 9'h02D;
  localparam logic [8:0] SC_P2_LEFT  = 9'h023;
  localparam logic [8:0] SC_P2_DOWN  = 9'h02B;
  localparam logic [8:0] SC_P2_RIGHT = 9'h034;
  localparam logic [8:0] SC_P2_FIRE  = 9'h01C;
  localparam logic [8:0] SC_P2_BOMB  = 9'h01B;

  // Arrows are matched on the low byte only
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam int JOY_R      = 0;
  localparam int JOY_L      = 1;
  localparam int JOY_D      = 2;
  localparam int JOY_U      = 3;
  localparam int JOY_FIRE   = 4;
  localparam int JOY_BOMB   = 5;
  localparam int JOY_START  = 6;
  localparam int JOY_START2 = 7;
  localparam int JOY_COIN   = 8;
  localparam int JOY_PAUSE  = 9;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arcade_inputs_coin.sv
// Coin pulse stretcher: keeps coin high for at least
// COIN_MIN cycles after each raw rising edge.
module coin_stretch
  import arcade_inputs_pkg::*;
#(
  parameter int COIN_MIN = 1800000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic raw,
  output logic out
);

  localparam int W = cnt_w(COIN_MIN);
  localparam logic [W-1:0] LOAD = W'(COIN_MIN - 1);

  logic         r_raw_q;
  logic [W-1:0] r_cnt;
  logic         r_out;
  logic         w_rise;

  assign w_rise = raw & ~r_raw_q;
  assign out    = r_out;

  // Edge detect, reload on rise, count down to zero and hold
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_raw_q <= 1'b0;
      r_cnt   <= '0;
      r_out   <= 1'b0;
    end else begin
      r_raw_q <= raw;
      r_out   <= raw | (r_cnt != '0);
      if (w_rise)
        r_cnt <= LOAD;
      else if (r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/arcade_inputs.sv
// Control-input front end: keyboard decode, joystick merge,
// coin stretching, service edge and DIP bank capture.
module arcade_inputs
  import arcade_inputs_pkg::*;
#(
  parameter int PLAYERS   = 2,
  parameter int DSW_BANKS = 2,
  parameter int DSW_INDEX = 254,
  parameter int COIN_MIN  = 1800000
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic [10:0]            ps2_key,
  input  logic [16*PLAYERS-1:0]  joystick,
  input  logic                   ioctl_wr,
  input  logic [7:0]             ioctl_index,
  input  logic [24:0]            ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  input  logic                   service_req,
  output logic [PLAYERS-1:0]     up,
  output logic [PLAYERS-1:0]     down,
  output logic [PLAYERS-1:0]     left,
  output logic [PLAYERS-1:0]     right,
  output logic [2*PLAYERS-1:0]   btn,
  output logic [PLAYERS-1:0]     start,
  output logic [PLAYERS-1:0]     coin,
  output logic                   service_key,
  output logic                   key_reset,
  output logic                   pause_req,
  output logic                   reset_pulse,
  output logic [8*DSW_BANKS-1:0] dsw
);

  logic       r_kev_q;
  logic [5:0] r_kjoy0, r_kjoy1;
  logic [1:0] r_kstart, r_kcoin;
  logic       r_kf3, r_ksvc;

  logic       w_kev, w_prs;
  logic [8:0] w_code;
  logic [7:0] w_lo;

  assign w_kev  = r_kev_q ^ ps2_key[10];
  assign w_prs  = ps2_key[9];
  assign w_code = ps2_key[8:0];
  assign w_lo   = ps2_key[7:0];

  // Key event decode into per-function key registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_kev_q  <= 1'b0;
      r_kjoy0  <= '0;
      r_kjoy1  <= '0;
      r_kstart <= '0;
      r_kcoin  <= '0;
      r_kf3    <= 1'b0;
      r_ksvc   <= 1'b0;
    end else begin
      r_kev_q <= ps2_key[10];
      if (w_kev) begin
        unique case (1'b1)
          (w_lo == SC_RIGHT):       r_kjoy0[JOY_R]    <= w_prs;
          (w_lo == SC_LEFT):        r_kjoy0[JOY_L]    <= w_prs;
          (w_lo == SC_DOWN):        r_kjoy0[JOY_D]    <= w_prs;
          (w_lo == SC_UP):          r_kjoy0[JOY_U]    <= w_prs;
          (w_code == SC_P1_FIRE):   r_kjoy0[JOY_FIRE] <= w_prs;
          (w_code == SC_P1_BOMB):   r_kjoy0[JOY_BOMB] <= w_prs;
          (w_code == SC_P2_RIGHT):  r_kjoy1[JOY_R]    <= w_prs;
          (w_code == SC_P2_LEFT):   r_kjoy1[JOY_L]    <= w_prs;
          (w_code == SC_P2_DOWN):   r_kjoy1[JOY_D]    <= w_prs;
          (w_code == SC_P2_UP):     r_kjoy1[JOY_U]    <= w_prs;
          (w_code == SC_P2_FIRE):   r_kjoy1[JOY_FIRE] <= w_prs;
          (w_code == SC_P2_BOMB):   r_kjoy1[JOY_BOMB] <= w_prs;
          (w_code == SC_START1):    r_kstart[0]       <= w_prs;
          (w_code == SC_START2):    r_kstart[1]       <= w_prs;
          (w_code == SC_COIN1):     r_kcoin[0]        <= w_prs;
          (w_code == SC_COIN2):     r_kcoin[1]        <= w_prs;
          (w_code == SC_F3):        r_kf3             <= w_prs;
          (w_code == SC_SERVICE):   r_ksvc            <= w_prs;
          default: ;
        endcase
      end
    end
  end

  // Zero-padded views so every player slot 0..3 can be indexed
  logic [63:0]      w_joy;
  logic [3:0][5:0]  w_kjoy;
  logic [3:0]       w_kst, w_kcn;
  logic             w_unused;

  assign w_joy    = 64'(joystick);
  assign w_kjoy   = {6'b0, 6'b0, r_kjoy1, r_kjoy0};
  assign w_kst    = {2'b0, r_kstart};
  assign w_kcn    = {2'b0, r_kcoin};
  assign w_unused = ^w_joy;

  logic [PLAYERS-1:0]   w_up, w_down, w_left, w_right;
  logic [PLAYERS-1:0]   w_start, w_coin_raw, w_coin;
  logic [2*PLAYERS-1:0] w_btn;
  logic                 w_pause;

  // Merge joystick bits with keys per player
  always_comb begin
    w_up       = '0;
    w_down     = '0;
    w_left     = '0;
    w_right    = '0;
    w_btn      = '0;
    w_start    = '0;
    w_coin_raw = '0;
    w_pause    = 1'b0;
    for (int p = 0; p < PLAYERS; p++) begin
      w_right[p]    = w_joy[16*p+JOY_R] | w_kjoy[p][JOY_R];
      w_left[p]     = w_joy[16*p+JOY_L] | w_kjoy[p][JOY_L];
      w_down[p]     = w_joy[16*p+JOY_D] | w_kjoy[p][JOY_D];
      w_up[p]       = w_joy[16*p+JOY_U] | w_kjoy[p][JOY_U];
      w_btn[2*p]    = w_joy[16*p+JOY_FIRE] | w_kjoy[p][JOY_FIRE];
      w_btn[2*p+1]  = w_joy[16*p+JOY_BOMB] | w_kjoy[p][JOY_BOMB];
      w_start[p]    = w_joy[16*p+JOY_START]
                    | w_joy[16*(p^1)+JOY_START2]
                    | w_kst[p];
      w_coin_raw[p] = w_joy[16*p+JOY_COIN] | w_kcn[p];
      w_pause       = w_pause | w_joy[16*p+JOY_PAUSE];
    end
  end

  logic [PLAYERS-1:0]   r_up, r_down, r_left, r_right, r_start;
  logic [2*PLAYERS-1:0] r_btn;
  logic                 r_pause, r_service_key, r_key_reset;

  // Output registers for merged controls and system keys
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_up          <= '0;
      r_down        <= '0;
      r_left        <= '0;
      r_right       <= '0;
      r_btn         <= '0;
      r_start       <= '0;
      r_pause       <= 1'b0;
      r_service_key <= 1'b0;
      r_key_reset   <= 1'b0;
    end else begin
      r_up          <= w_up;
      r_down        <= w_down;
      r_left        <= w_left;
      r_right       <= w_right;
      r_btn         <= w_btn;
      r_start       <= w_start;
      r_pause       <= w_pause;
      r_service_key <= r_ksvc;
      r_key_reset   <= r_kf3;
    end
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_coin
    coin_stretch #(
      .COIN_MIN (COIN_MIN)
    ) u_coin (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .raw     (w_coin_raw[p]),
      .out     (w_coin[p])
    );
  end

  logic r_svc_s1, r_svc_s2, r_svc_d, r_reset_pulse;

  // Synchronise service request and pulse on its rising edge
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_svc_s1      <= 1'b0;
      r_svc_s2      <= 1'b0;
      r_svc_d       <= 1'b0;
      r_reset_pulse <= 1'b0;
    end else begin
      r_svc_s1      <= service_req;
      r_svc_s2      <= r_svc_s1;
      r_svc_d       <= r_svc_s2;
      r_reset_pulse <= r_svc_s2 & ~r_svc_d;
    end
  end

  logic [DSW_BANKS-1:0][7:0] r_dsw;

  // DIP banks stored inverted; out-of-range addresses fall through
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_dsw <= '1;
    end else if (ioctl_wr && ioctl_index == 8'(DSW_INDEX)) begin
      for (int b = 0; b < DSW_BANKS; b++)
        if (ioctl_addr == 25'(b))
          r_dsw[b] <= ~ioctl_dout;
    end
  end

  assign up          = r_up;
  assign down        = r_down;
  assign left        = r_left;
  assign right       = r_right;
  assign btn         = r_btn;
  assign start       = r_start;
  assign coin        = w_coin;
  assign pause_req   = r_pause;
  assign service_key = r_service_key;
  assign key_reset   = r_key_reset;
  assign reset_pulse = r_reset_pulse;
  assign dsw         = r_dsw;

endmodule

// File: tb/tb_arcade_inputs.sv
// Directed bench for arcade_inputs with 2 players,
// 2 DIP banks and an 8-cycle coin minimum.
module tb_arcade_inputs;

  localparam int PL = 2;
  localparam int NB = 2;
  localparam int CM = 8;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic [10:0]   ps2_key = '0;
  logic [31:0]   joystick = '0;
  logic          ioctl_wr = 1'b0;
  logic [7:0]    ioctl_index = '0;
  logic [24:0]   ioctl_addr = '0;
  logic [7:0]    ioctl_dout = '0;
  logic          service_req = 1'b0;
  logic [PL-1:0] up, down, left, right, start, coin;
  logic [3:0]    btn;
  logic          service_key, key_reset, pause_req, reset_pulse;
  logic [15:0]   dsw;

  arcade_inputs #(
    .PLAYERS   (PL),
    .DSW_BANKS (NB),
    .DSW_INDEX (254),
    .COIN_MIN  (CM)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ps2_key     (ps2_key),
    .joystick    (joystick),
    .ioctl_wr    (ioctl_wr),
    .ioctl_index (ioctl_index),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .service_req (service_req),
    .up          (up),
    .down        (down),
    .left        (left),
    .right       (right),
    .btn         (btn),
    .start       (start),
    .coin        (coin),
    .service_key (service_key),
    .key_reset   (key_reset),
    .pause_req   (pause_req),
    .reset_pulse (reset_pulse),
    .dsw         (dsw)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [14:0] bundle();
    return {up, down, left, right, btn, start, pause_req};
  endfunction

  function automatic logic [14:0] mk(input logic [1:0] u, d, l, r,
                                     input logic [3:0] b,
                                     input logic [1:0] s,
                                     input logic p);
    return {u, d, l, r, b, s, p};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic send_key(input logic [10:0] code);
    ps2_key = {~ps2_key[10], code[9:0]};
  endtask

  task automatic dip_wr(input logic [7:0] idx, input logic [24:0] a,
                        input logic [7:0] d);
    ioctl_wr    = 1'b1;
    ioctl_index = idx;
    ioctl_addr  = a;
    ioctl_dout  = d;
    step(1);
    ioctl_wr    = 1'b0;
  endtask

  task automatic coin_run(input int hold, input int re,
                          output int cnt, output int last);
    cnt  = 0;
    last = -1;
    for (int k = 0; k < 40; k++) begin
      if (coin[0]) begin
        cnt++;
        last = k;
      end
      joystick[8] = (k < hold) || (k == re);
      step(1);
    end
  endtask

  typedef struct {
    logic [31:0] joy;
    logic [14:0] exp;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int cnt, last, pc, first;

    tbl[0]  = '{32'h0000_0000, mk(0, 0, 0, 0, 4'b0000, 0, 0)};
    tbl[1]  = '{32'h0000_0001, mk(0, 0, 0, 1, 4'b0000, 0, 0)};
    tbl[2]  = '{32'h0000_0008, mk(1, 0, 0, 0, 4'b0000, 0, 0)};
    tbl[3]  = '{32'h0004_0002, mk(0, 2, 1, 0, 4'b0000, 0, 0)};
    tbl[4]  = '{32'h0000_0030, mk(0, 0, 0, 0, 4'b0011, 0, 0)};
    tbl[5]  = '{32'h0030_0000, mk(0, 0, 0, 0, 4'b1100, 0, 0)};
    tbl[6]  = '{32'h0000_0080, mk(0, 0, 0, 0, 4'b0000, 2, 0)};
    tbl[7]  = '{32'h0080_0000, mk(0, 0, 0, 0, 4'b0000, 1, 0)};
    tbl[8]  = '{32'h0040_0040, mk(0, 0, 0, 0, 4'b0000, 3, 0)};
    tbl[9]  = '{32'h0200_0000, mk(0, 0, 0, 0, 4'b0000, 0, 1)};
    tbl[10] = '{32'h0000_0200, mk(0, 0, 0, 0, 4'b0000, 0, 1)};
    tbl[11] = '{32'h0010_0004, mk(0, 1, 0, 0, 4'b0100, 0, 0)};
    tbl[12] = '{32'h0001_0008, mk(1, 0, 0, 2, 4'b0000, 0, 0)};

    // Reset: held, then released
    step(3);
    check("rst_hold_ctl", bundle(), 15'h0);
    check("rst_hold_dsw", dsw, 16'hFFFF);
    check("rst_hold_misc",
          {coin, service_key, key_reset, reset_pulse}, 5'h0);
    reset_n = 1'b1;
    step(2);
    check("rst_rel_ctl", bundle(), 15'h0);
    check("rst_rel_dsw", dsw, 16'hFFFF);

    // Joystick merge table
    for (int i = 0; i < 13; i++) begin
      joystick = tbl[i].joy;
      step(1);
      check($sformatf("joy_vec%0d", i), bundle(), tbl[i].exp);
    end
    joystick = '0;
    step(1);

    // DIP banks
    dip_wr(8'd254, 25'd0, 8'h3C);
    check("dip_next_cycle", dsw, 16'hFFC3);
    dip_wr(8'd254, 25'd1, 8'h01);
    dip_wr(8'd254, 25'd2, 8'h55);
    check("dip_load", dsw, 16'hFEC3);
    dip_wr(8'd0, 25'd0, 8'h00);
    dip_wr(8'd0, 25'd1, 8'h00);
    check("dip_other_index", dsw, 16'hFEC3);
    dip_wr(8'd254, 25'h100_0000, 8'h00);
    check("dip_high_addr", dsw, 16'hFEC3);
    dip_wr(8'd254, 25'd0, 8'hAA);
    dip_wr(8'd254, 25'd0, 8'h0F);
    check("dip_last_wins", dsw, 16'hFEF0);

    // Key decode
    send_key(11'h275);
    step(1);
    check("key_up_lat1", up, 2'b00);
    step(1);
    check("key_up_lat2", up, 2'b01);
    send_key(11'h075);
    step(2);
    check("key_up_rel", up, 2'b00);
    send_key(11'h372);
    step(2);
    check("key_down_ext", down, 2'b01);
    send_key(11'h072);
    step(2);
    send_key(11'h314);
    step(2);
    check("key_ext_fire_ign", btn, 4'b0000);
    send_key(11'h214);
    step(2);
    check("key_fire", btn, 4'b0001);
    joystick = 32'h0000_0010;
    send_key(11'h014);
    step(2);
    check("key_joy_or", btn, 4'b0001);
    joystick = '0;
    step(1);
    check("fire_clear", btn, 4'b0000);
    send_key(11'h22D);
    step(2);
    check("key_p2_up", up, 2'b10);
    send_key(11'h02D);
    step(2);

    // Key event together with a DIP write
    send_key(11'h204);
    ioctl_wr    = 1'b1;
    ioctl_index = 8'd254;
    ioctl_addr  = 25'd1;
    ioctl_dout  = 8'h0F;
    step(1);
    ioctl_wr = 1'b0;
    check("simul_dsw", dsw, 16'hF0F0);
    step(1);
    check("simul_key_reset", key_reset, 1'b1);
    send_key(11'h004);
    step(2);
    check("key_reset_rel", key_reset, 1'b0);
    send_key(11'h246);
    step(2);
    check("service_key", service_key, 1'b1);
    send_key(11'h046);
    step(2);

    // Coin stretch
    coin_run(1, -1, cnt, last);
    check("coin_pulse_cnt", cnt, 8);
    check("coin_pulse_last", last, 8);
    coin_run(20, -1, cnt, last);
    check("coin_hold_cnt", cnt, 20);
    coin_run(1, 5, cnt, last);
    check("coin_retrig_cnt", cnt, 13);
    check("coin_retrig_last", last, 13);
    send_key(11'h22E);
    step(1);
    check("coin_key_lat1", coin, 2'b00);
    step(1);
    check("coin_key_lat2", coin, 2'b01);
    send_key(11'h02E);
    step(12);
    check("coin_key_done", coin, 2'b00);
    send_key(11'h236);
    step(2);
    check("coin2_key", coin, 2'b10);
    send_key(11'h036);
    step(12);

    // Reset in the middle of a stretch
    joystick[8] = 1'b1;
    step(1);
    joystick[8] = 1'b0;
    step(2);
    check("coin_mid", coin[0], 1'b1);
    reset_n = 1'b0;
    #1;
    check("coin_async_clr", coin[0], 1'b0);
    check("dsw_async_rst", dsw, 16'hFFFF);
    step(1);
    reset_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      step(1);
      if (coin[0]) cnt++;
    end
    check("coin_no_resume", cnt, 0);

    // Service edge
    service_req = 1'b1;
    pc    = 0;
    first = 0;
    for (int k = 1; k <= 100; k++) begin
      step(1);
      if (reset_pulse) begin
        pc++;
        if (first == 0) first = k;
      end
    end
    check("svc_pulse_cnt", pc, 1);
    check("svc_pulse_lat", first, 3);
    service_req = 1'b0;
    pc = 0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      if (reset_pulse) pc++;
    end
    check("svc_fall_none", pc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
